// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters, with a registered, back-pressurable response.
// Optional statistics counters (op_count, stall_count) are built when ALU_ARB_STATS_EN is defined.

package alu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6
    } alu_op_t;
endpackage

module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  alu_op_t      op_i,
    output logic [N-1:0] result_o,
    output logic         carry_o,
    output logic         zero_o
);
    logic [N:0] wide;

    always_comb begin
        wide     = '0;
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            ALU_ADD: begin
                wide     = {1'b0, a_i} + {1'b0, b_i};
                result_o = wide[N-1:0];
                carry_o  = wide[N];
            end
            ALU_SUB: begin
                // The borrow lands in the extra top bit exactly when a_i < b_i.
                wide     = {1'b0, a_i} - {1'b0, b_i};
                result_o = wide[N-1:0];
                carry_o  = wide[N];
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SHL: result_o = a_i << b_i[3:0];
            ALU_SHR: result_o = a_i >> b_i[3:0];
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);
endmodule

module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int N       = 16,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  logic [N-1:0]        req_a [NUM_REQ],
    input  logic [N-1:0]        req_b [NUM_REQ],
    input  alu_op_t             req_op [NUM_REQ],
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [N-1:0]        rsp_result,
    output logic                rsp_carry,
    output logic                rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]         op_count,
    output logic [31:0]         stall_count
`endif
);
    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [N-1:0]    rsp_result_q, rsp_result_d;
    logic            rsp_carry_q, rsp_carry_d;
    logic            rsp_zero_q, rsp_zero_d;

    logic [ID_W:0]   cand_sum [NUM_REQ];
    logic [ID_W-1:0] cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_vld;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] grant_next;
    logic            any_valid;
    logic            accept_ok;
    logic            xfer;

    logic [N-1:0]    alu_a, alu_b, alu_result;
    alu_op_t         alu_op;
    logic            alu_carry, alu_zero;

    // Candidate gi is the requester gi places above ptr_q, wrapped modulo NUM_REQ.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr_q} + (ID_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (ID_W+1)'(NUM_REQ))
                                ? ID_W'(cand_sum[gi] - (ID_W+1)'(NUM_REQ))
                                : cand_sum[gi][ID_W-1:0];
            assign cand_vld[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the nearest valid candidate to ptr_q wins.
    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                grant_idx = cand_idx[k];
                any_valid = 1'b1;
            end
        end
    end

    assign grant_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign accept_ok  = (state_q == ST_EMPTY) || rsp_ready;
    assign xfer       = !rst && any_valid && accept_ok;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = xfer && (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign alu_a  = req_a[grant_idx];
    assign alu_b  = req_b[grant_idx];
    assign alu_op = req_op[grant_idx];

    alu_arbiter_alu #(
        .N (N)
    ) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_result),
        .carry_o  (alu_carry),
        .zero_o   (alu_zero)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        if (xfer) begin
            state_d      = ST_FULL;
            ptr_d        = grant_next;
            rsp_id_d     = grant_idx;
            rsp_result_d = alu_result;
            rsp_carry_d  = alu_carry;
            rsp_zero_d   = alu_zero;
        end else begin
            case (state_q)
                ST_FULL:  if (rsp_ready) state_d = ST_EMPTY;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            ptr_q        <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign rsp_valid  = (state_q == ST_FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] op_count_q, op_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        stall_cycle;

    assign stall_cycle = rsp_valid && !rsp_ready && (|req_valid);

    always_comb begin
        op_count_d    = op_count_q;
        stall_count_d = stall_count_q;
        if (xfer && (op_count_q != 32'hFFFF_FFFF)) begin
            op_count_d = op_count_q + 32'd1;
        end
        if (stall_cycle && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            op_count_q    <= op_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign op_count    = op_count_q;
    assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a cycle-level reference model checked every cycle plus literal spot checks.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N  = 16;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [N-1:0]  req_a [NR];
    logic [N-1:0]  req_b [NR];
    alu_op_t       req_op [NR];
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [N-1:0]  rsp_result;
    logic          rsp_carry;
    logic          rsp_zero;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]   op_count;
    logic [31:0]   stall_count;
`endif

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.N(N), .NUM_REQ(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_STATS_EN
        ,
        .op_count   (op_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic using plain integer maths.
    task automatic ref_alu(input logic [15:0] a, input logic [15:0] b, input alu_op_t op,
                           output logic [15:0] r, output logic c);
        int unsigned ua, ub;
        ua = a;
        ub = b;
        r  = 16'h0;
        c  = 1'b0;
        case (op)
            ALU_ADD: begin r = 16'(ua + ub); c = (ua + ub) > 65535; end
            ALU_SUB: begin r = 16'(ua - ub); c = (ua < ub); end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SHL: r = 16'(ua * (32'd1 << (ub % 16)));
            ALU_SHR: r = 16'(ua / (32'd1 << (ub % 16)));
            default: begin r = 16'h0; c = 1'b0; end
        endcase
    endtask

    // Reference model state: what the response port must hold after each edge.
    bit          m_init = 0;
    int          m_ptr;
    logic        m_valid;
    logic [1:0]  m_id;
    logic [15:0] m_res;
    logic        m_carry;
    logic        m_zero;
    int unsigned m_ops;
    int unsigned m_stalls;

    // Inputs only change just after a rising edge, so at the falling edge they are the
    // values the next rising edge will sample.
    always @(negedge clk) begin
        int          g;
        logic [3:0]  exp_ready;
        logic [15:0] r;
        logic        c;
        g = -1;
        for (int k = 0; k < NR; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        end
        exp_ready = (!rst && (!m_valid || rsp_ready) && g >= 0) ? 4'(1 << g) : 4'h0;
        if (m_init) begin
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
            chk("m_rsp_result", 32'(rsp_result), 32'(m_res));
            chk("m_rsp_carry", 32'(rsp_carry), 32'(m_carry));
            chk("m_rsp_zero", 32'(rsp_zero), 32'(m_zero));
            chk("m_req_ready", 32'(req_ready), 32'(exp_ready));
`ifdef ALU_ARB_STATS_EN
            chk("m_op_count", op_count, m_ops);
            chk("m_stall_count", stall_count, m_stalls);
`endif
        end
        if (rst) begin
            m_init   = 1;
            m_ptr    = 0;
            m_valid  = 1'b0;
            m_id     = 2'd0;
            m_res    = 16'h0;
            m_carry  = 1'b0;
            m_zero   = 1'b0;
            m_ops    = 0;
            m_stalls = 0;
        end else if (m_init) begin
            if (m_valid && !rsp_ready && (req_valid != 0)) m_stalls++;
            if (exp_ready != 4'h0) begin
                ref_alu(req_a[g], req_b[g], req_op[g], r, c);
                m_valid = 1'b1;
                m_id    = 2'(g);
                m_res   = r;
                m_carry = c;
                m_zero  = (r == 16'h0);
                m_ptr   = (g + 1) % NR;
                m_ops++;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one_op(input int idx, input logic [15:0] a, input logic [15:0] b, input alu_op_t op,
                          input logic [15:0] er, input logic ec, input logic ez, input string name);
        step();
        req_a[idx]  = a;
        req_b[idx]  = b;
        req_op[idx] = op;
        req_valid   = 4'(1 << idx);
        step();
        req_valid = 4'h0;
        @(negedge clk);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_id"}, 32'(rsp_id), 32'(idx));
        chk({name, "_result"}, 32'(rsp_result), 32'(er));
        chk({name, "_carry"}, 32'(rsp_carry), 32'(ec));
        chk({name, "_zero"}, 32'(rsp_zero), 32'(ez));
    endtask

    int rr_ids [5] = '{0, 1, 2, 3, 0};
    int rr_res [5] = '{3, 7, 16'h0F0F, 16'h0034, 3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'h0;
        for (int i = 0; i < NR; i++) begin
            req_a[i]  = 16'h0;
            req_b[i]  = 16'h0;
            req_op[i] = ALU_ADD;
        end
        repeat (2) step();
        @(negedge clk);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_result", 32'(rsp_result), 32'd0);
        chk("reset_zero", 32'(rsp_zero), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;

        // Single ADD with carry-out and zero result
        req_a[0]  = 16'hFFFF;
        req_b[0]  = 16'h0001;
        req_op[0] = ALU_ADD;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("add_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'h0;
        @(negedge clk);
        chk("add_valid", 32'(rsp_valid), 32'd1);
        chk("add_id", 32'(rsp_id), 32'd0);
        chk("add_result", 32'(rsp_result), 32'h0000);
        chk("add_carry", 32'(rsp_carry), 32'd1);
        chk("add_zero", 32'(rsp_zero), 32'd1);

        one_op(1, 16'h0003, 16'h0005, ALU_SUB, 16'hFFFE, 1'b1, 1'b0, "sub");
        one_op(2, 16'h0001, 16'h0013, ALU_SHL, 16'h0008, 1'b0, 1'b0, "shl");
        one_op(3, 16'h8000, 16'h000F, ALU_SHR, 16'h0001, 1'b0, 1'b0, "shr");
        one_op(0, 16'hF0F0, 16'h0FF0, ALU_XOR, 16'hFF00, 1'b0, 1'b0, "xor");
        one_op(1, 16'hF0F0, 16'h0FF0, ALU_OR,  16'hFFF0, 1'b0, 1'b0, "or");
        one_op(2, 16'h1234, 16'h5678, alu_op_t'(3'd7), 16'h0000, 1'b0, 1'b1, "undef");

        // Round robin from a fresh pointer
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_a[0] = 16'h0001; req_b[0] = 16'h0002; req_op[0] = ALU_ADD;
        req_a[1] = 16'h000A; req_b[1] = 16'h0003; req_op[1] = ALU_SUB;
        req_a[2] = 16'hF0F0; req_b[2] = 16'hFFFF; req_op[2] = ALU_XOR;
        req_a[3] = 16'h1234; req_b[3] = 16'h00FF; req_op[3] = ALU_AND;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(rr_ids[k]));
            chk("rr_result", 32'(rsp_result), 32'(rr_res[k]));
        end

        // Backpressure: hold the id-1 response for three cycles
        step();
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_result", 32'(rsp_result), 32'd7);
            chk("bp_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready), 32'b0100);
        step();
        @(negedge clk);
        chk("bp_next_id", 32'(rsp_id), 32'd2);
        chk("bp_next_result", 32'(rsp_result), 32'h0F0F);

        // Reset mid-operation with a held response and ptr = 2
        step();
        req_valid = 4'b0010;
        step();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        chk("midrst_pre_id", 32'(rsp_id), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_result", 32'(rsp_result), 32'd0);
        chk("midrst_id", 32'(rsp_id), 32'd0);
        chk("midrst_carry", 32'(rsp_carry), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'b0001);
        step();
        @(negedge clk);
        chk("midrst_grant_id", 32'(rsp_id), 32'd0);
        chk("midrst_grant_result", 32'(rsp_result), 32'd3);

        // A lone requester is granted on consecutive cycles
        step();
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("lone_valid", 32'(rsp_valid), 32'd1);
            chk("lone_id", 32'(rsp_id), 32'd2);
        end
        step();
        req_valid = 4'h0;

`ifdef ALU_ARB_STATS_EN
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        repeat (2) step();
        rsp_ready = 1'b0;
        repeat (3) step();
        rsp_ready = 1'b1;
        repeat (3) step();
        req_valid = 4'h0;
        step();
        @(negedge clk);
        chk("stats_op_count", op_count, 32'd5);
        chk("stats_stall_count", stall_count, 32'd3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("stats_reset_op", op_count, 32'd0);
        chk("stats_reset_stall", stall_count, 32'd0);
`endif

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
